// File: rtl/slave_mem_pkg.sv
// Shared definitions for the burst slave memory: FSM state encoding,
// derived geometry constants and parameter legality checks.
// No ports (package).
package slave_mem_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrite = 2'd1,
    StRead  = 2'd2
  } state_e;

  // Byte lanes per word (NB).
  function automatic int unsigned calc_nb(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Words in the array (MEM_DEPTH).
  function automatic int unsigned calc_mem_depth(input int unsigned mem_size,
                                                 input int unsigned data_width);
    return mem_size / (data_width / 8);
  endfunction

  // Word address width (MEM_AW).
  function automatic int unsigned calc_mem_aw(input int unsigned mem_depth);
    return $clog2(mem_depth);
  endfunction

  // Output FIFO entries (FIFO_DEPTH): enough to cover the read pipeline plus
  // two beats of slack so issue can keep one beat per cycle.
  function automatic int unsigned calc_fifo_depth(input int unsigned read_latency);
    return read_latency + 2;
  endfunction

  // Word width must be whole bytes and the read latency 1 or 2.
  function automatic bit params_legal(input int unsigned data_width,
                                      input int unsigned read_latency);
    return (data_width != 0) && (data_width % 8 == 0) &&
           ((read_latency == 1) || (read_latency == 2));
  endfunction

endpackage

// File: rtl/slave_mem_array.sv
// Byte-lane-write, synchronous-read memory with READ_LATENCY register stages.
// No reset on the data path so the array maps onto block RAM.
// Ports:
//   clk    clock
//   we     write enable; lanes selected by wstrb are written at waddr
//   waddr  write word address
//   wdata  write data
//   wstrb  byte enables
//   re     read enable; rdata shows mem[raddr] READ_LATENCY cycles later
//   raddr  read word address
//   rdata  read data
module slave_mem_array #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned AW           = 12,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [AW-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rd_q <= mem[raddr];
    end
  end

  if (READ_LATENCY == 2) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd2_q;
    always_ff @(posedge clk) begin
      rd2_q <= rd_q;
    end
    assign rdata = rd2_q;
  end else begin : g_no_out_reg
    assign rdata = rd_q;
  end

endmodule

// File: rtl/slave_memory_burst_ctrl.sv
// Burst slave memory: byte-strobe incrementing write bursts and credit-controlled
// read bursts through a small output FIFO, backed by slave_mem_array.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_wr, req_addr, req_len  direction, start word address, beats minus one
//   wvalid/wready, wdata, wstrb  write beat channel (ready only while writing)
//   rvalid/rready, rdata, rlast  read beat channel, rlast on the final beat
module slave_memory_burst_ctrl
  import slave_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned MEM_SIZE     = 4096,
  parameter int unsigned LEN_WIDTH    = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LEN_WIDTH-1:0]    req_len,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rlast
);

  localparam int unsigned MEM_DEPTH  = calc_mem_depth(MEM_SIZE, DATA_WIDTH);
  localparam int unsigned MEM_AW     = calc_mem_aw(MEM_DEPTH);
  localparam int unsigned FIFO_DEPTH = calc_fifo_depth(READ_LATENCY);
  localparam int unsigned FIFO_PW    = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W      = FIFO_CW + 1;

  if (!params_legal(DATA_WIDTH, READ_LATENCY) || (ADDR_WIDTH < MEM_AW)) begin : g_bad_params
    $error("slave_memory_burst_ctrl: illegal DATA_WIDTH/READ_LATENCY/ADDR_WIDTH");
  end

  if (ADDR_WIDTH > MEM_AW) begin : g_addr_hi
    // Address bits above the array size are ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:MEM_AW];
  end

  function automatic logic [MEM_AW-1:0] ptr_inc(input logic [MEM_AW-1:0] p);
    return (p == MEM_AW'(MEM_DEPTH - 1)) ? '0 : p + MEM_AW'(1);
  endfunction

  function automatic logic [FIFO_PW-1:0] fptr_inc(input logic [FIFO_PW-1:0] p);
    return (p == FIFO_PW'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PW'(1);
  endfunction

  state_e state_q, state_d;

  logic [MEM_AW-1:0]    ptr_q, ptr_d;
  // Write beats left (WRITE) or reads still to issue (READ).
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

  logic accept, wbeat, pop, push, push_last;
  logic issue, issue_last, credit_ok;
  logic [MEM_AW-1:0] issue_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_last_q;
  logic [FIFO_CW-1:0]      inflight;

  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [FIFO_PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [FIFO_CW-1:0]    fifo_cnt_q;

  assign accept    = req_valid & req_ready;
  assign wbeat     = wvalid & wready;
  assign rvalid    = (fifo_cnt_q != '0);
  assign rdata     = fifo_data_q[rd_ptr_q];
  assign rlast     = rvalid & fifo_last_q[rd_ptr_q];
  assign pop       = rvalid & rready;
  assign push      = pipe_vld_q[READ_LATENCY-1];
  assign push_last = pipe_last_q[READ_LATENCY-1];

  // FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = req_wr ? StWrite : StRead;
      StWrite: if (wbeat && (cnt_q == '0)) state_d = StIdle;
      StRead:  if (pop && rlast) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    req_ready = (state_q == StIdle);
    wready    = (state_q == StWrite);
  end

  // Reads in flight in the memory pipeline; counted as occupying FIFO credit.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + FIFO_CW'(pipe_vld_q[i]);
    end
  end

  assign credit_ok = (SUM_W'(fifo_cnt_q) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);

  // The first read beat is issued straight from the request so the first
  // rvalid lands READ_LATENCY+1 cycles after acceptance.
  always_comb begin
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = ptr_q;
    if (state_q == StIdle) begin
      issue      = accept & ~req_wr;
      issue_addr = req_addr[MEM_AW-1:0];
      issue_last = (req_len == '0);
    end else if (state_q == StRead) begin
      issue      = (cnt_q != '0) && credit_ok;
      issue_last = (cnt_q == LEN_WIDTH'(1));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = req_len;
      ptr_d = req_wr ? req_addr[MEM_AW-1:0] : ptr_inc(req_addr[MEM_AW-1:0]);
    end else if (wbeat || issue) begin
      ptr_d = ptr_inc(ptr_q);
      cnt_d = cnt_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Valid/last tags travelling alongside the memory read pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q[0]  <= issue;
      pipe_last_q[0] <= issue & issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
    end
  end

  // FIFO control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      fifo_last_q <= '0;
    end else begin
      if (push) begin
        fifo_last_q[wr_ptr_q] <= push_last;
        wr_ptr_q              <= fptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= fptr_inc(rd_ptr_q);
      end
      fifo_cnt_q <= fifo_cnt_q + FIFO_CW'(push) - FIFO_CW'(pop);
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_rdata;
    end
  end

  slave_mem_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (MEM_DEPTH),
    .AW          (MEM_AW),
    .READ_LATENCY(READ_LATENCY)
  ) u_mem (
    .clk  (clk),
    .we   (wbeat),
    .waddr(ptr_q),
    .wdata(wdata),
    .wstrb(wstrb),
    .re   (issue),
    .raddr(issue_addr),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_slave_memory_burst_ctrl.sv
// Bench for slave_memory_burst_ctrl: two instances (read latency 1 and 2) share
// all request/write/rready stimulus; each read channel is checked beat by beat
// against a word-array model of the memory and a queue of expected beats.
module tb_slave_memory_burst_ctrl;
  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 32;
  localparam int unsigned LW  = 4;
  localparam int unsigned NBT = DW / 8;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic wvalid = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [NBT-1:0] wstrb = '0;
  logic rready = 1'b1;

  logic req_ready_a, wready_a, rvalid_a, rlast_a;
  logic req_ready_b, wready_b, rvalid_b, rlast_b;
  logic [DW-1:0] rdata_a, rdata_b;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rr_mode = 0;

  logic [DW-1:0]  model_mem [DEPTH];
  beat_t          q0[$];
  beat_t          q1[$];
  logic [DW-1:0]  wbuf_d [16];
  logic [NBT-1:0] wbuf_s [16];

  bit            await_first [2];
  bit            stalled [2];
  logic [DW-1:0] hold_data [2];
  logic          hold_last [2];
  logic [DW-1:0] last_pop [2];
  int            pops [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  slave_memory_burst_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(4096), .LEN_WIDTH(LW), .READ_LATENCY(1)
  ) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .wvalid(wvalid), .wready(wready_a),
    .wdata(wdata), .wstrb(wstrb), .rvalid(rvalid_a), .rready(rready), .rdata(rdata_a),
    .rlast(rlast_a)
  );

  slave_memory_burst_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(4096), .LEN_WIDTH(LW), .READ_LATENCY(2)
  ) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_b), .req_wr(req_wr),
    .req_addr(req_addr), .req_len(req_len), .wvalid(wvalid), .wready(wready_b),
    .wdata(wdata), .wstrb(wstrb), .rvalid(rvalid_b), .rready(rready), .rdata(rdata_b),
    .rlast(rlast_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Read channel checker for both instances.
  always @(negedge clk) begin
    logic v, l;
    logic [DW-1:0] dat;
    beat_t b;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        v   = (d == 0) ? rvalid_a : rvalid_b;
        l   = (d == 0) ? rlast_a : rlast_b;
        dat = (d == 0) ? rdata_a : rdata_b;
        if (v && await_first[d]) begin
          check($sformatf("first_rvalid_latency_rl%0d", d + 1), 32'(cyc - acc_cyc), 32'(d + 1));
          await_first[d] = 1'b0;
        end
        if (stalled[d]) begin
          check($sformatf("rvalid_held_rl%0d", d + 1), 32'(v), 32'd1);
          if (v) begin
            check($sformatf("rdata_stable_rl%0d", d + 1), dat, hold_data[d]);
            check($sformatf("rlast_stable_rl%0d", d + 1), 32'(l), 32'(hold_last[d]));
          end
        end
        if (v && rready) begin
          stalled[d] = 1'b0;
          if (((d == 0) ? q0.size() : q1.size()) == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_beat_rl%0d: got beat 0x%08h, required none", d + 1, dat);
          end else begin
            b = (d == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rdata_rl%0d", d + 1), dat, b.data);
            check($sformatf("rlast_rl%0d", d + 1), 32'(l), 32'(b.last));
            last_pop[d] = dat;
            pops[d]++;
          end
        end else if (v) begin
          stalled[d]   = 1'b1;
          hold_data[d] = dat;
          hold_last[d] = l;
        end else begin
          stalled[d] = 1'b0;
        end
      end
    end
  end

  // rready patterns: 0 = always, 1 = random, 2 = repeating 1,0,0,1.
  initial begin
    int idx = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: rready = 1'b1;
        1: rready = ($urandom_range(0, 2) != 0);
        default: rready = ((idx % 4) == 0) || ((idx % 4) == 3);
      endcase
      idx++;
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(req_ready_a && req_ready_b)) begin
      n++;
      if (n > 300) begin
        tests++;
        fails++;
        $display("FAIL idle_timeout: req_ready %0b/%0b, required 1/1", req_ready_a, req_ready_b);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d beats outstanding, required 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic do_req(input bit wr, input logic [AW-1:0] addr, input int len);
    beat_t b;
    int base;
    wait_idle();
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_len   = LW'(len);
    @(negedge clk);
    req_valid = 1'b0;
    if (!wr) begin
      base = int'(addr) % DEPTH;
      for (int i = 0; i <= len; i++) begin
        b.data = model_mem[(base + i) % DEPTH];
        b.last = (i == len);
        q0.push_back(b);
        q1.push_back(b);
      end
      acc_cyc        = cyc;
      await_first[0] = 1'b1;
      await_first[1] = 1'b1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input int len, input bit gaps);
    int i = 0;
    int guard = 0;
    int a;
    do_req(1'b1, addr, len);
    a = int'(addr) % DEPTH;
    while (i <= len) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
      end else begin
        wvalid = 1'b1;
        wdata  = wbuf_d[i];
        wstrb  = wbuf_s[i];
        if (wready_a && wready_b) begin
          for (int k = 0; k < NBT; k++) begin
            if (wbuf_s[i][k]) model_mem[a][8*k +: 8] = wbuf_d[i][8*k +: 8];
          end
          a = (a + 1) % DEPTH;
          i++;
        end else begin
          guard++;
          if (guard > 8) begin
            tests++;
            fails++;
            $display("FAIL wready_timeout: wready %0b/%0b, required 1/1", wready_a, wready_b);
            break;
          end
        end
      end
      @(negedge clk);
    end
    wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input int len);
    do_req(1'b0, addr, len);
  endtask

  initial begin
    int p0;
    int n;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rvalid", 32'({rvalid_a, rvalid_b}), 32'd0);
    check("rst_rlast", 32'({rlast_a, rlast_b}), 32'd0);
    check("rst_wready", 32'({wready_a, wready_b}), 32'd0);
    check("rst_req_ready", 32'({req_ready_a, req_ready_b}), 32'd3);
    rst = 1'b0;

    // Clear the whole array so every later read has a defined expectation.
    for (int i = 0; i < 16; i++) begin
      wbuf_d[i] = '0;
      wbuf_s[i] = '1;
    end
    for (int blk = 0; blk < DEPTH / 16; blk++) do_write(AW'(blk * 16), 15, 1'b0);
    check("wready_after_write", 32'({wready_a, wready_b}), 32'd0);

    // Full-strobe write then read.
    rr_mode = 0;
    wbuf_d[0] = 32'h11111111;
    wbuf_d[1] = 32'h22222222;
    wbuf_d[2] = 32'h33333333;
    wbuf_d[3] = 32'h44444444;
    do_write(12'h010, 3, 1'b0);
    check("model_full_strobe", model_mem[12'h012], 32'h33333333);
    do_read(12'h010, 3);
    wait_drain();
    check("full_last_a", last_pop[0], 32'h44444444);
    check("full_last_b", last_pop[1], 32'h44444444);

    // Partial strobe over zero.
    wbuf_d[0] = 32'hAABBCCDD;
    wbuf_s[0] = 4'b0101;
    do_write(12'h005, 0, 1'b0);
    check("model_partial", model_mem[5], 32'h00BB00DD);
    do_read(12'h005, 0);
    wait_drain();
    check("partial_a", last_pop[0], 32'h00BB00DD);
    check("partial_b", last_pop[1], 32'h00BB00DD);

    // Wrap-around.
    for (int i = 0; i < 4; i++) begin
      wbuf_d[i] = DW'(i + 1);
      wbuf_s[i] = '1;
    end
    do_write(12'h3FE, 3, 1'b0);
    check("model_wrap0", model_mem[0], 32'd3);
    check("model_wrap1", model_mem[1], 32'd4);
    do_read(12'h3FE, 3);
    wait_drain();
    check("wrap_last_a", last_pop[0], 32'd4);
    do_read(12'h000, 0);
    wait_drain();
    check("wrap_word0_a", last_pop[0], 32'd3);
    check("wrap_word0_b", last_pop[1], 32'd3);

    // Back-pressure with the 1,0,0,1 rready pattern.
    for (int i = 0; i < 8; i++) begin
      wbuf_d[i] = $urandom;
      wbuf_s[i] = '1;
    end
    do_write(12'h100, 7, 1'b1);
    rr_mode = 2;
    p0 = pops[0];
    n  = pops[1];
    do_read(12'h100, 7);
    wait_drain();
    check("bp_beats_a", 32'(pops[0] - p0), 32'd8);
    check("bp_beats_b", 32'(pops[1] - n), 32'd8);
    check("bp_last_a", last_pop[0], model_mem[12'h107]);

    // Reset in the middle of a read burst.
    rr_mode = 0;
    p0 = pops[0];
    do_read(12'h010, 7);
    n = 0;
    while (pops[0] < p0 + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_rvalid", 32'(rvalid_a), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rvalid", 32'({rvalid_a, rvalid_b}), 32'd0);
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      stalled[d]     = 1'b0;
      await_first[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'({req_ready_a, req_ready_b}), 32'd3);
    do_read(12'h012, 0);
    wait_drain();
    check("post_rst_read_a", last_pop[0], 32'h33333333);
    check("post_rst_read_b", last_pop[1], 32'h33333333);

    // Randomized mix of bursts.
    rr_mode = 1;
    for (int t = 0; t < 60; t++) begin
      int len;
      len = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wbuf_d[i] = $urandom;
          wbuf_s[i] = NBT'($urandom);
        end
        do_write(AW'($urandom), len, 1'b1);
      end else begin
        do_read(AW'($urandom), len);
      end
    end
    wait_drain();
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slave_memory_burst_ctrl.md
Name: slave_memory_burst_ctrl

Overview:
- Next-generation slave memory for the serial bus: a parametrised BRAM-backed slave with DATA_WIDTH-wide words, byte-strobe writes, and incrementing bursts.
- Adds configurable read latency (1 or 2) and back-pressured read data through a credit-controlled output FIFO.
- Sits behind the slave bus port; the single-beat 8-bit slave becomes the special case LEN=0, DATA_WIDTH=8, READ_LATENCY=1.

Parameters:
- ADDR_WIDTH, 12, request word-address width; upper bits beyond MEM_AW are ignored.
- DATA_WIDTH, 8, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- MEM_SIZE, 4096, memory size in bytes; MEM_DEPTH = MEM_SIZE/NB words; MEM_AW = $clog2(MEM_DEPTH).
- LEN_WIDTH, 4, burst length field width; a burst has req_len+1 beats (1..16).
- READ_LATENCY, 1, BRAM read latency; legal values are 1 or 2 (2 adds an output register stage).

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset, asynchronous, active-high.
- req_valid  in  1  Request valid.
- req_ready  out  1  Request accept; high only in IDLE.
- req_wr  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_WIDTH  Start word address.
- req_len  in  LEN_WIDTH  Beats minus 1.
- wvalid  in  1  Write beat valid.
- wready  out  1  Write beat accept; high only in WRITE.
- wdata  in  DATA_WIDTH  Write data.
- wstrb  in  NB  Byte enables.
- rvalid  out  1  Read beat valid.
- rready  in  1  Read beat accept.
- rdata  out  DATA_WIDTH  Read data.
- rlast  out  1  Last beat of the read burst.

Behaviour:
- Reset: state = IDLE; rvalid = 0, rlast = 0, wready = 0; req_ready = 1 while in IDLE; FIFO is emptied and in-flight counters are cleared.
- Memory contents are not reset; simulation initialises them to 0. Reset asserted mid-burst aborts the burst, discards in-flight reads, and returns to IDLE.
- FSM states are IDLE, WRITE, READ.
- IDLE: on req_valid & req_ready, latch addr[MEM_AW-1:0] into ptr and req_len into beat counter cnt.
  - If req_wr = 1, go to WRITE; otherwise go to READ.
- WRITE:
  - On each wvalid & wready, for every lane i with wstrb[i] = 1, mem[ptr][8i+7:8i] <= wdata lane i; lanes with wstrb[i] = 0 keep their value.
  - After each beat, ptr increments modulo MEM_DEPTH (wraps at MEM_DEPTH-1 to 0) and cnt decrements.
  - The beat taken with cnt = 0 returns the FSM to IDLE on the next cycle.
- READ issue:
  - A BRAM read is issued when issued_beats <= req_len and (fifo_count + inflight) < FIFO_DEPTH, where FIFO_DEPTH = READ_LATENCY + 2.
  - ptr increments with wrap on each issue.
  - Data returns READ_LATENCY cycles after issue and is pushed into the FIFO together with an rlast tag (set on the final beat).
- READ output:
  - rvalid = FIFO not empty; rdata and rlast come from the FIFO head; the head is popped on rvalid & rready.
  - The pop with rlast = 1 returns the FSM to IDLE on the next cycle.
  - req_ready goes high in that IDLE cycle, so there is one dead cycle between bursts.
- Latency: for a request accepted at cycle T with rready held high, the first rvalid is at T+1+READ_LATENCY; after that, one beat per cycle.
- Back-pressure: while rready = 0, issue stalls once credits are exhausted. No beat is ever lost or duplicated, and rdata is held stable while rvalid & !rready.
- Ordering: a write at cycle N is visible to any read issued at cycle N+1 or later.
- Wrap-around: bursts crossing MEM_DEPTH-1 continue at word 0.

Decomposition:
- Package slave_mem_pkg holds:
  - FSM state encoding.
  - Constants NB, MEM_DEPTH, MEM_AW, and FIFO_DEPTH.
  - Checks that DATA_WIDTH % 8 = 0 and READ_LATENCY is in {1, 2}.
- Sub-module slave_mem_array: byte-lane-write, synchronous-read BRAM with READ_LATENCY stages and no reset on the data path, so block RAM is inferred.
- The output FIFO and the FSM stay in the top module.

Test Plan (DATA_WIDTH=32, MEM_SIZE=4096, so MEM_DEPTH=1024):
- Full-strobe write then read:
  - Stimulus: write addr 0x010, len 3, data 0x11111111..0x44444444, wstrb 0xF; then read addr 0x010, len 3, rready = 1.
  - Required: 4 beats in order, rlast on the 4th beat, first rvalid at T+1+READ_LATENCY.
- Partial strobe:
  - Stimulus: write 0xAABBCCDD with wstrb 0b0101 over existing 0x00000000 at addr 5; read addr 5.
  - Required: read returns 0x00BB00DD.
- Wrap-around:
  - Stimulus: write addr 0x3FE, len 3, data 1, 2, 3, 4; read addr 0x3FE, len 3.
  - Required: 1, 2, 3, 4 returned; mem[0x000] = 3 and mem[0x001] = 4.
- Back-pressure:
  - Stimulus: read len 7 with rready toggling 1, 0, 0, 1 repeatedly, for READ_LATENCY = 1 and READ_LATENCY = 2.
  - Required: all 8 beats correct, no drop or duplicate, rdata stable while stalled.
- Reset mid-burst:
  - Stimulus: assert rst after 2 beats of a len-7 read; release it.
  - Required: rvalid = 0 immediately (asynchronous), req_ready = 1 after release, and a following read of len 0 returns correct data.
